// File: rtl/serial_word_deser_pkg.sv
// Shared types and constants for the serial-to-word deserializer.
package deser_pkg;

    // Default word width, matching the 32-bit pattern counter downstream.
    localparam int WORD_W_DEF = 32;

    // FILL: accepting bits. STALL: full word parked in the shift register.
    typedef enum logic {
        FILL  = 1'b0,
        STALL = 1'b1
    } deser_state_t;

    // Ceiling log2, used to size the bit counter so it can hold WORD_W.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_word_deser_if.sv
// Serial bit input plus word valid/ready output of the deserializer.
interface serial_word_deser_if
    import deser_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF
) ();

    logic              bit_in;
    logic              bit_valid;
    logic              bit_ready;
    logic              flush;
    logic [WORD_W-1:0] word_out;
    logic              word_valid;
    logic              word_ready;
    logic              overflow;

    // Source/sink side: drives bits, flush and word_ready.
    modport master (
        output bit_in, bit_valid, flush, word_ready,
        input  bit_ready, word_out, word_valid, overflow
    );

    // Deserializer side.
    modport slave (
        input  bit_in, bit_valid, flush, word_ready,
        output bit_ready, word_out, word_valid, overflow
    );

endinterface

// File: rtl/serial_word_deser_word_hold_reg.sv
// Output holding register with valid/ready: load, hold until consumed, release.
module word_hold_reg
    import deser_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [WORD_W-1:0] load_data_i,
    input  logic              ready_i,
    output logic [WORD_W-1:0] word_o,
    output logic              valid_o
);

    logic [WORD_W-1:0] word_q, word_d;
    logic              valid_q, valid_d;

    // Next-state: a load wins over a consume; a consume alone drops valid but keeps the data.
    always_comb begin
        // NOTE: defaults first so every path assigns both signals and no latch is inferred.
        word_d  = word_q;
        valid_d = valid_q;
        if (load_i) begin
            word_d  = load_data_i;
            valid_d = 1'b1;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the data register is reset too, because word_out must read 0 out of reset.
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    assign word_o  = word_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/serial_word_deser.sv
// MSB-first serial-to-word deserializer, double-buffered ahead of the pattern counter.
module serial_word_deser
    import deser_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_word_deser_if.slave bus
);

    localparam int               CNT_W    = clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_W);

    deser_state_t      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic              overflow_q, overflow_d;

    logic [WORD_W-1:0] shifted;
    logic              bit_ready;
    logic              handshake;
    logic              hold_free;
    logic              accept;
    logic              load;
    logic [WORD_W-1:0] load_data;

    assign shifted = {shift_q[WORD_W-2:0], bus.bit_in};

    // State register: FSM state, bit count, shift register and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FILL;
            cnt_q      <= '0;
            shift_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            overflow_q <= overflow_d;
        end
    end

    // Next-state: flush overrides everything; otherwise fill, complete or stall.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        overflow_d = overflow_q | (bus.bit_valid & ~bit_ready);
        if (bus.flush) begin
            state_d    = FILL;
            cnt_d      = '0;
            shift_d    = '0;
            overflow_d = 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (accept) begin
                        shift_d = shifted;
                        if (cnt_q == CNT_LAST) begin
                            if (hold_free) begin
                                cnt_d = '0;
                            end else begin
                                cnt_d   = CNT_FULL;
                                state_d = STALL;
                            end
                        end else begin
                            cnt_d = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + CNT_W'(1);
                        end
                    end
                end
                STALL: begin
                    if (handshake) begin
                        cnt_d   = '0;
                        state_d = FILL;
                    end
                end
                default: state_d = FILL;
            endcase
        end
    end

    // Outputs: bit acceptance and when/what to load into the holding register.
    always_comb begin
        bit_ready = (state_q == FILL);
        handshake = bus.word_valid & bus.word_ready;
        hold_free = ~bus.word_valid | handshake;
        accept    = bus.bit_valid & bit_ready & ~bus.flush;
        load      = 1'b0;
        load_data = shifted;
        if (!bus.flush) begin
            if (state_q == FILL && accept && cnt_q == CNT_LAST && hold_free) begin
                load = 1'b1;
            end else if (state_q == STALL && handshake) begin
                load      = 1'b1;
                load_data = shift_q;
            end
        end
    end

    word_hold_reg #(
        .WORD_W (WORD_W)
    ) u_hold (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (load),
        .load_data_i (load_data),
        .ready_i     (bus.word_ready),
        .word_o      (bus.word_out),
        .valid_o     (bus.word_valid)
    );

    assign bus.bit_ready = bit_ready;
    assign bus.overflow  = overflow_q;

endmodule
